regfile_multiport_sb: RTL
=========================

Name: regfile_multiport_sb

Overview:
- Parametrised successor to the CPU's 16x32 three-read/one-write register file.
- Generalises data width, register count and read-port count.
- Adds per-port read enables, a pending-write scoreboard (busy bits) for the decode/hazard logic, and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits between the decode/register-read stage and writeback.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- NUM_REGS, 16, number of architectural registers (>=2, need not be a power of 2).
- NUM_READ_PORTS, 3, number of synchronous read ports (>=1).
- ZERO_REG, 1: when 1, register 0 reads as 0, ignores writes and is never busy.
- SEL_W, $clog2(NUM_REGS), derived select width; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clear_req  in  1  request a full array clear (honoured only in READY)
- ready  out  1  high when array is usable
- rd_en  in  NUM_READ_PORTS  per-port read enable
- rd_sel  in  NUM_READ_PORTS*SEL_W  packed selects, port i at [i*SEL_W +: SEL_W]
- rd_data  out  NUM_READ_PORTS*DATA_WIDTH  packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- rd_busy  out  NUM_READ_PORTS  busy flag of the register sampled on port i
- wr_en  in  1  write strobe
- wr_sel  in  SEL_W  write select
- wr_data  in  DATA_WIDTH  write data
- rsv_en  in  1  reserve (mark busy) strobe
- rsv_sel  in  SEL_W  register to reserve
- busy_vec  out  NUM_REGS  full scoreboard

Behaviour:
- Reset (async, rst=1):
  - State goes to CLEAR, sweep index = 0.
  - ready=0, rd_data=0, rd_busy=0, busy_vec=0.
  - Storage array is not reset directly; it is zeroed by the sweep.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 to mem[idx], then idx+1.
  - The cycle that writes idx=NUM_REGS-1 transitions to READY; ready=1 from the next cycle. After rst deasserts, ready rises at the NUM_REGS-th rising edge.
  - wr_en, rsv_en and clear_req are ignored; busy_vec held 0.
  - rd_en updates rd_data to 0 and rd_busy to 0.
- READY to CLEAR:
  - clear_req=1 in READY enters CLEAR with idx=0 and busy_vec=0 at the next edge; ready=0 in the same edge.
  - A wr_en/rsv_en in that same cycle is dropped.
- Write (READY only):
  - wr_en=1 writes mem[wr_sel] <= wr_data and clears busy[wr_sel].
  - The write is ignored if wr_sel>=NUM_REGS, or if ZERO_REG=1 and wr_sel=0.
- Reserve (READY only):
  - rsv_en=1 sets busy[rsv_sel]. Same range and zero-register exclusions as writes.
  - rsv_en and wr_en on the same register in the same cycle: busy ends 1 (new producer wins); data is still written.
- Read:
  - Latency 1. For each port i with rd_en[i]=1, at the clock edge:
    - rd_data[i] <= 0 if sel is out of range, or if ZERO_REG=1 and sel=0.
    - Otherwise rd_data[i] <= wr_data if a valid write targets the same sel this cycle (write-through bypass).
    - Otherwise rd_data[i] <= mem[sel].
  - rd_busy[i] <= next-state busy of sel (after this cycle's clear/reserve update).
  - rd_en[i]=0: rd_data[i] and rd_busy[i] hold.
  - Ports are fully independent; any number may select the same register.
- busy_vec is registered; it reflects updates one cycle after the strobe.
- Reset mid-sweep restarts the sweep from idx=0.
- Reset while READY discards all busy bits; array contents become 0 only via the sweep.

Test Plan:
- Defaults. Release rst at cycle 0 -> ready=0 through edge 15, ready=1 after edge 16. Every port reading regs 0..15 returns 0x00000000 and rd_busy=0.
- Write plus bypass. Write reg 5=0xDEADBEEF with rd_en[0]=1, rd_sel[0]=5 in the same cycle -> next cycle rd_data[0]=0xDEADBEEF. Next cycle read of reg 5 on port 2 -> 0xDEADBEEF.
- Zero register. Write reg 0=0x12345678 plus rsv reg 0 -> read reg 0 gives 0, busy_vec[0]=0. With ZERO_REG=0 the same stimulus -> read gives 0x12345678, busy_vec[0]=1.
- Scoreboard.
  - rsv reg 7 -> busy_vec=0x0080 next cycle.
  - Later write reg 7=0xA5 with a concurrent rsv of reg 7 -> busy_vec[7] stays 1.
  - Write reg 7 alone -> busy_vec[7]=0.
  - Read reg 7 in the rsv cycle -> rd_busy=1.
- Clear request. Load regs 1..4 with nonzero values, rsv reg 3, pulse clear_req -> ready=0 and busy_vec=0 next cycle. A wr_en during the sweep has no effect. ready returns after 16 cycles and all reads return 0.
- Parametric config. DATA_WIDTH=64, NUM_REGS=10, NUM_READ_PORTS=4: sweep takes 10 cycles; read of sel 12 -> 0; write to sel 12 ignored; four ports reading regs 1,1,9,0 simultaneously return the correct values.

Source files
------------

// File: rtl/regfile_multiport_sb_if.sv
// Register-file bundle between decode/register-read and writeback: read ports, write port, reserve port, clear.
interface regfile_multiport_sb_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 16,
  parameter int NUM_READ_PORTS = 3,
  parameter int SEL_W          = $clog2(NUM_REGS)
);
  logic                                 clear_req;
  logic                                 ready;
  logic [NUM_READ_PORTS-1:0]            rd_en;
  logic [NUM_READ_PORTS*SEL_W-1:0]      rd_sel;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ_PORTS-1:0]            rd_busy;
  logic                                 wr_en;
  logic [SEL_W-1:0]                     wr_sel;
  logic [DATA_WIDTH-1:0]                wr_data;
  logic                                 rsv_en;
  logic [SEL_W-1:0]                     rsv_sel;
  logic [NUM_REGS-1:0]                  busy_vec;

  modport master (
    output clear_req, rd_en, rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
    input  ready, rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  clear_req, rd_en, rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
    output ready, rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_multiport_sb.sv
// Multi-read-port register file with pending-write scoreboard and a zeroing sweep after reset/clear.
// Reads registered (1 cycle) with same-cycle write bypass; no backpressure, callers gate on ready.
module regfile_multiport_sb #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 16,
  parameter int NUM_READ_PORTS = 3,
  parameter int ZERO_REG       = 1,
  parameter int SEL_W          = $clog2(NUM_REGS)
) (
  input logic                   clk,
  input logic                   rst,
  regfile_multiport_sb_if.slave bus
);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                                   state, state_nxt;
  logic [SEL_W-1:0]                         idx;
  logic                                     ready, sweep_we, wr_ok, rsv_ok;
  logic [NUM_REGS-1:0]                      busy_q, busy_nxt;
  logic [DATA_WIDTH-1:0]                    mem [NUM_REGS];
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_q, rd_nxt;
  logic [NUM_READ_PORTS-1:0]                rb_q, rb_nxt;
  logic [SEL_W-1:0]                         rsel;

  // Out-of-range selects and the hardwired zero register are neither stored nor tracked.
  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return (int'(s) < NUM_REGS) && !((ZERO_REG != 0) && (s == '0));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (idx == LAST_IDX) state_nxt = ST_READY;
      ST_READY: if (bus.clear_req)   state_nxt = ST_CLEAR;
      default:                       state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    ready    = (state == ST_READY);
    sweep_we = (state == ST_CLEAR);
    wr_ok    = ready && !bus.clear_req && bus.wr_en  && sel_ok(bus.wr_sel);
    rsv_ok   = ready && !bus.clear_req && bus.rsv_en && sel_ok(bus.rsv_sel);
  end

  // Sweep index parks at 0 outside CLEAR so a new clear always starts from the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              idx <= '0;
    else if (sweep_we && idx != LAST_IDX) idx <= idx + SEL_W'(1);
    else                                  idx <= '0;
  end

  always_ff @(posedge clk) begin
    if (sweep_we)   mem[idx]        <= '0;
    else if (wr_ok) mem[bus.wr_sel] <= bus.wr_data;
  end

  // Reserve is applied after the write-clear so a new producer wins on a collision.
  always_comb begin
    busy_nxt = busy_q;
    if (!ready || bus.clear_req) begin
      busy_nxt = '0;
    end else begin
      if (wr_ok)  busy_nxt[bus.wr_sel]  = 1'b0;
      if (rsv_ok) busy_nxt[bus.rsv_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  always_comb begin
    rd_nxt = '0;
    rb_nxt = '0;
    rsel   = '0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      rsel = bus.rd_sel[i*SEL_W +: SEL_W];
      if (ready && sel_ok(rsel)) begin
        rd_nxt[i] = (wr_ok && bus.wr_sel == rsel) ? bus.wr_data : mem[rsel];
        rb_nxt[i] = busy_nxt[rsel];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      rb_q <= '0;
    end else begin
      for (int i = 0; i < NUM_READ_PORTS; i++) begin
        if (bus.rd_en[i]) begin
          rd_q[i] <= rd_nxt[i];
          rb_q[i] <= rb_nxt[i];
        end
      end
    end
  end

  assign bus.ready    = ready;
  assign bus.busy_vec = busy_q;
  assign bus.rd_data  = rd_q;
  assign bus.rd_busy  = rb_q;
endmodule
